fetch_unit: RTL and testbench

- Instruction-fetch front end of the pipelined RV32I core, directly upstream of the decode stage.
- Generates the PC stream and issues word requests to instruction memory over a valid/ready request channel.
- Collects in-order responses into a small buffer and presents {instr, pc, pc+4} to decode over a valid/ready handshake.
- Handles EX-stage redirects (taken branch, jal) by flushing buffered and in-flight fetches.

---
 rtl/fetch_unit.sv | 96 +++++++++
 tb/tb_fetch_unit.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: RV32I fetch front end; issues imem word requests, buffers in-order responses, feeds decode, flushes on redirect.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic {BOOT, RUN} state_t;
  state_t state, state_nx;
  logic [31:0] fetch_pc;
  logic [CW-1:0] inflight_cnt, drop_cnt, fifo_cnt;
  logic [AW-1:0] q_wp, q_rp, f_wp, f_rp;
  logic [31:0] pc_q [DEPTH];
  logic [31:0] instr_mem [DEPTH];
  logic [31:0] pc_mem [DEPTH];
  logic req_fire, rsp_live, drop_rsp, id_pop, has_head;
  // credit covers in-flight, to-be-dropped and buffered entries, so the fifo can never overflow
  always_comb begin
    state_nx = state == BOOT ? RUN : state;
    imem_req_valid = state == RUN && !redirect_valid && (inflight_cnt + drop_cnt + fifo_cnt < CW'(DEPTH));
    req_fire = imem_req_valid && imem_req_ready;
    drop_rsp = imem_rsp_valid && drop_cnt != '0;
    rsp_live = imem_rsp_valid && drop_cnt == '0;
    has_head = fifo_cnt != '0;
    id_valid = has_head && !redirect_valid;
    id_pop = id_valid && id_ready;
    id_instr = has_head ? instr_mem[f_rp] : '0;
    id_pc = has_head ? pc_mem[f_rp] : '0;
    id_pc_plus4 = has_head ? pc_mem[f_rp] + 32'd4 : '0;
  end
  assign imem_req_addr = fetch_pc;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= BOOT;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      inflight_cnt <= '0;
      drop_cnt <= '0;
      fifo_cnt <= '0;
      q_wp <= '0;
      q_rp <= '0;
      f_wp <= '0;
      f_rp <= '0;
    end else if (redirect_valid) begin
      // every outstanding response becomes stale; one arriving now is discarded here
      fetch_pc <= {redirect_pc[31:2], 2'b00};
      inflight_cnt <= '0;
      drop_cnt <= drop_cnt + inflight_cnt - CW'(imem_rsp_valid);
      fifo_cnt <= '0;
      q_wp <= '0;
      q_rp <= '0;
      f_wp <= '0;
      f_rp <= '0;
    end else begin
      fetch_pc <= req_fire ? fetch_pc + 32'd4 : fetch_pc;
      inflight_cnt <= inflight_cnt + CW'(req_fire) - CW'(rsp_live);
      drop_cnt <= drop_cnt - CW'(drop_rsp);
      fifo_cnt <= fifo_cnt + CW'(rsp_live) - CW'(id_pop);
      q_wp <= req_fire ? q_wp + 1'b1 : q_wp;
      q_rp <= rsp_live ? q_rp + 1'b1 : q_rp;
      f_wp <= rsp_live ? f_wp + 1'b1 : f_wp;
      f_rp <= id_pop ? f_rp + 1'b1 : f_rp;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i] <= '0;
        instr_mem[i] <= '0;
        pc_mem[i] <= '0;
      end
    end else if (!redirect_valid) begin
      if (req_fire) pc_q[q_wp] <= fetch_pc;
      if (rsp_live) begin
        instr_mem[f_wp] <= imem_rsp_data;
        pc_mem[f_wp] <= pc_q[q_rp];
      end
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized bench for fetch_unit against a transaction-level model of memory, buffer and redirects.
module tb_fetch_unit;
  localparam int DEPTH = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  logic clk, rst_n;
  logic imem_req_valid, imem_req_ready, imem_rsp_valid, redirect_valid, id_valid, id_ready;
  logic [31:0] imem_req_addr, imem_rsp_data, redirect_pc, id_instr, id_pc, id_pc_plus4;
  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc), .id_pc_plus4(id_pc_plus4)
  );
  typedef struct {logic [31:0] addr; int due; bit stale;} req_t;
  typedef struct {logic [31:0] instr; logic [31:0] pc;} ent_t;
  req_t pend[$];
  ent_t mf[$];
  int checks = 0, errs = 0, cyc = 0, last_due = 0;
  int p_rdy, p_idr, p_red, lat_max;
  bit run, force_red;
  logic [31:0] force_pc, exp_addr;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction
  task automatic chk_reset();
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("rst_req_addr", imem_req_addr, RESET_PC);
    chk("rst_id_valid", {31'b0, id_valid}, 32'd0);
    chk("rst_id_instr", id_instr, 32'd0);
    chk("rst_id_pc", id_pc, 32'd0);
    chk("rst_id_pc_plus4", id_pc_plus4, 32'd0);
  endtask
  // entered at a falling edge; asserts rst_n between edges to observe the asynchronous clear
  task automatic do_reset();
    #3;
    rst_n = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b0;
    id_ready = 1'b0;
    #1;
    chk_reset();
    repeat (2) begin
      @(negedge clk);
      cyc++;
    end
    chk_reset();
    pend.delete();
    mf.delete();
    run = 1'b0;
    exp_addr = RESET_PC;
    last_due = cyc;
    rst_n = 1'b1;
  endtask
  // one clock cycle: drive at the falling edge, check, then advance the model to the next state
  task automatic step();
    bit exp_rv, exp_iv;
    int due;
    req_t r;
    ent_t e;
    redirect_valid = force_red || ($urandom_range(0, 99) < p_red);
    redirect_pc = force_red ? force_pc : $urandom;
    force_red = 1'b0;
    imem_req_ready = $urandom_range(0, 99) < p_rdy;
    id_ready = $urandom_range(0, 99) < p_idr;
    imem_rsp_valid = pend.size() != 0 && pend[0].due <= cyc;
    imem_rsp_data = imem_rsp_valid ? mem_f(pend[0].addr) : $urandom;
    #1;
    exp_rv = run && !redirect_valid && (pend.size() + mf.size() < DEPTH);
    exp_iv = mf.size() != 0 && !redirect_valid;
    chk("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_rv});
    if (exp_rv) chk("req_addr", imem_req_addr, exp_addr);
    chk("id_valid", {31'b0, id_valid}, {31'b0, exp_iv});
    if (exp_iv) begin
      chk("id_instr", id_instr, mf[0].instr);
      chk("id_pc", id_pc, mf[0].pc);
      chk("id_pc_plus4", id_pc_plus4, mf[0].pc + 32'd4);
    end
    if (exp_iv && id_ready) void'(mf.pop_front());
    assert (!imem_rsp_valid || pend.size() != 0);
    if (imem_rsp_valid) begin
      r = pend.pop_front();
      if (!r.stale && !redirect_valid) begin
        e.instr = imem_rsp_data;
        e.pc = r.addr;
        mf.push_back(e);
      end
    end
    if (imem_req_valid && imem_req_ready) begin
      due = cyc + int'($urandom_range(1, lat_max));
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      r.addr = imem_req_addr;
      r.due = due;
      r.stale = 1'b0;
      pend.push_back(r);
    end
    if (redirect_valid) begin
      exp_addr = {redirect_pc[31:2], 2'b00};
      mf.delete();
      foreach (pend[i]) pend[i].stale = 1'b1;
    end else if (exp_rv && imem_req_ready) exp_addr = exp_addr + 32'd4;
    run = 1'b1;
    @(negedge clk);
    cyc++;
  endtask
  initial begin
    rst_n = 1'b0;
    force_red = 1'b0;
    force_pc = '0;
    redirect_pc = '0;
    imem_rsp_data = '0;
    exp_addr = RESET_PC;
    @(negedge clk);
    do_reset();
    p_rdy = 100; p_idr = 100; p_red = 0; lat_max = 1;
    repeat (20) step();
    p_idr = 0;
    repeat (8) step();
    p_idr = 100;
    repeat (8) step();
    p_rdy = 0;
    repeat (5) step();
    p_rdy = 100; lat_max = 3;
    repeat (4) step();
    force_red = 1'b1; force_pc = 32'h0000_0103;
    repeat (15) step();
    force_red = 1'b1; force_pc = 32'hFFFF_FFFD;
    repeat (12) step();
    p_rdy = 70; p_idr = 70; p_red = 5; lat_max = 4;
    repeat (3000) step();
    do_reset();
    p_rdy = 80; p_idr = 60; p_red = 8; lat_max = 3;
    repeat (500) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errs);
    $finish;
  end
endmodule
